// File: rtl/vga_syncgen.sv
// VGA raster timing generator: scan counters plus sync, display-enable and line/frame strobes.
// Decoded outputs lag the counters by 1+PIPE_DLY cycles; counters themselves are not delayed.
module vga_syncgen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int PIPE_DLY  = 0
) (
    input  logic       PCK,
    input  logic       RST,
    output logic [9:0] HCNT,
    output logic [9:0] VCNT,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       DE,
    output logic       LINE_START,
    output logic       FRAME_START
);

    localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (HTOTAL > 1024 || VTOTAL > 1024 || HTOTAL < 2 || VTOTAL < 1 ||
            PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_cfg_err
            $error("vga_syncgen: timing totals must fit 10 bits and PIPE_DLY must be 0..7");
        end
    endgenerate

    // Decode thresholds are 11 bits so a sync region ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_DE_END = 11'(H_ACTIVE);
    localparam logic [10:0] H_SY_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SY_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_DE_END = 11'(V_ACTIVE);
    localparam logic [10:0] V_SY_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SY_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  H_LAST   = 10'(HTOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(VTOTAL - 1);

    // Order: {frame_start, line_start, de, vsync, hsync}
    localparam logic [4:0]  IDLE     = {1'b0, 1'b0, 1'b0, ~VSYNC_POL, ~HSYNC_POL};

    always_ff @(posedge PCK) begin
        if (RST) begin
            HCNT <= '0;
            VCNT <= '0;
        end else if (HCNT == H_LAST) begin
            HCNT <= '0;
            VCNT <= (VCNT == V_LAST) ? '0 : VCNT + 10'd1;
        end else begin
            HCNT <= HCNT + 10'd1;
        end
    end

    logic [10:0] hx;
    logic [10:0] vx;
    logic        de_raw;
    logic        hs_raw;
    logic        vs_raw;
    logic        ls_raw;
    logic        fs_raw;
    logic [4:0]  raw;

    assign hx = {1'b0, HCNT};
    assign vx = {1'b0, VCNT};

    // Sync polarity is applied here so the pipeline carries pin levels.
    always_comb begin
        de_raw = (hx < H_DE_END) && (vx < V_DE_END);
        hs_raw = ((hx >= H_SY_BEG) && (hx < H_SY_END)) ? HSYNC_POL : ~HSYNC_POL;
        vs_raw = ((vx >= V_SY_BEG) && (vx < V_SY_END)) ? VSYNC_POL : ~VSYNC_POL;
        ls_raw = (HCNT == 10'd0);
        fs_raw = (HCNT == 10'd0) && (VCNT == 10'd0);
        raw    = {fs_raw, ls_raw, de_raw, vs_raw, hs_raw};
    end

    logic [4:0] pipe [PIPE_DLY+1];

    always_ff @(posedge PCK) begin
        if (RST) begin
            for (int i = 0; i <= PIPE_DLY; i++) pipe[i] <= IDLE;
        end else begin
            pipe[0] <= raw;
            for (int i = 1; i <= PIPE_DLY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign {FRAME_START, LINE_START, DE, VSYNC, HSYNC} = pipe[PIPE_DLY];

endmodule
